// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit byte channel among N_REQ producers.
// Optional SEND watchdog is enabled by defining UART_TX_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int          N_REQ      = 4,
    parameter int          GAP_CYCLES = 16,
    parameter logic [7:0]  IDLE_BYTE  = 8'h00
`ifdef UART_TX_TIMEOUT_EN
    ,
    parameter int          TIMEOUT_CYCLES = 4096
`endif
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     req_ack,
    output logic [N_REQ-1:0]     req_done,
    input  logic                 block,
    output logic [7:0]           tx_bits,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic [2:0]           grant_id,
    output logic                 tx_err,
    output logic [7:0]           timeout_cnt
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         grant_id_q, grant_id_d;
    logic [N_REQ-1:0]   req_ack_q, req_ack_d;
    logic [N_REQ-1:0]   req_done_q, req_done_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [7:0]         hold_q, hold_d;

    logic               win_found;
    logic [2:0]         win_idx;
    int                 cand;

    function automatic logic [N_REQ-1:0] onehot(input logic [2:0] id);
        onehot = {{(N_REQ-1){1'b0}}, 1'b1} << id;
    endfunction

    // Scan from the requester after the last grant, wrapping, so priority rotates.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 3'd0;
        cand      = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = (int'(grant_id_q) + i) % N_REQ;
            if (!win_found && (1'((req_valid >> cand)) == 1'b1)) begin
                win_found = 1'b1;
                win_idx   = 3'(cand);
            end
        end
    end

`ifdef UART_TX_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic               tx_err_q, tx_err_d;
    logic [7:0]         timeout_cnt_q, timeout_cnt_d;
`endif

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        req_ack_d  = '0;
        req_done_d = '0;
        gap_cnt_d  = gap_cnt_q;
        hold_d     = hold_q;
`ifdef UART_TX_TIMEOUT_EN
        to_cnt_d      = to_cnt_q;
        tx_err_d      = 1'b0;
        timeout_cnt_d = timeout_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!block && win_found) begin
                    state_d    = ST_SEND;
                    grant_id_d = win_idx;
                    req_ack_d  = onehot(win_idx);
                    hold_d     = 8'(req_data >> (8 * int'(win_idx)));
`ifdef UART_TX_TIMEOUT_EN
                    to_cnt_d   = '0;
`endif
                end
            end
            ST_SEND: begin
                // tx_ready wins over a watchdog expiry in the same cycle.
                if (tx_ready) begin
                    req_done_d = onehot(grant_id_q);
                    gap_cnt_d  = '0;
                    state_d    = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                end
`ifdef UART_TX_TIMEOUT_EN
                else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    req_done_d = onehot(grant_id_q);
                    tx_err_d   = 1'b1;
                    gap_cnt_d  = '0;
                    state_d    = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                    if (timeout_cnt_q != 8'hFF) begin
                        timeout_cnt_d = timeout_cnt_q + 8'd1;
                    end
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`endif
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            grant_id_q <= 3'(N_REQ - 1);
            req_ack_q  <= '0;
            req_done_q <= '0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            req_ack_q  <= req_ack_d;
            req_done_q <= req_done_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    // The held byte is only observed in SEND, which always loads it first.
    always_ff @(posedge clock) begin
        hold_q <= hold_d;
    end

`ifdef UART_TX_TIMEOUT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            to_cnt_q      <= '0;
            tx_err_q      <= 1'b0;
            timeout_cnt_q <= 8'd0;
        end else begin
            to_cnt_q      <= to_cnt_d;
            tx_err_q      <= tx_err_d;
            timeout_cnt_q <= timeout_cnt_d;
        end
    end

    assign tx_err      = tx_err_q;
    assign timeout_cnt = timeout_cnt_q;
`else
    assign tx_err      = 1'b0;
    assign timeout_cnt = 8'd0;
`endif

    assign tx_bits  = (state_q == ST_SEND) ? hold_q : IDLE_BYTE;
    assign busy     = (state_q != ST_IDLE);
    assign grant_id = grant_id_q;
    assign req_ack  = req_ack_q;
    assign req_done = req_done_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (N_REQ=4, GAP_CYCLES=16).
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int N_REQ = 4;
    localparam int GAP   = 16;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic [N_REQ-1:0]   req_valid = '0;
    logic [8*N_REQ-1:0] req_data = '0;
    logic [N_REQ-1:0]   req_ack;
    logic [N_REQ-1:0]   req_done;
    logic               block = 1'b0;
    logic [7:0]         tx_bits;
    logic               tx_ready = 1'b0;
    logic               busy;
    logic [2:0]         grant_id;
    logic               tx_err;
    logic [7:0]         timeout_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    uart_tx_arbiter #(
        .N_REQ(N_REQ),
        .GAP_CYCLES(GAP),
        .IDLE_BYTE(8'h00)
`ifdef UART_TX_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(64)
`endif
    ) dut (
        .clock(clock),
        .reset(reset),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ack(req_ack),
        .req_done(req_done),
        .block(block),
        .tx_bits(tx_bits),
        .tx_ready(tx_ready),
        .busy(busy),
        .grant_id(grant_id),
        .tx_err(tx_err),
        .timeout_cnt(timeout_cnt)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_ack();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (req_ack != '0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("ack_wait", 32'd0, 32'd1);
    endtask

    task automatic send_done(input logic [N_REQ-1:0] exp_done);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        check("done", req_done, exp_done);
        check("gap_bits", tx_bits, 8'h00);
        tick(GAP - 1);
        check("gap_busy", busy, 1'b1);
        tick();
        check("idle_busy", busy, 1'b0);
        check("idle_done", req_done, '0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tick(2);
        check("rst_busy", busy, 1'b0);
        check("rst_bits", tx_bits, 8'h00);
        check("rst_ack", req_ack, '0);
        check("rst_done", req_done, '0);
        check("rst_gid", grant_id, 3'd3);
        check("rst_err", tx_err, 1'b0);
        check("rst_tocnt", timeout_cnt, 8'd0);
        reset = 1'b1;
        tick(2);

        // single requester, first grant
        req_data  = {8'h33, 8'h22, 8'h11, 8'h05};
        req_valid = 4'b0001;
        tick();
        check("s_ack", req_ack, 4'b0001);
        check("s_gid", grant_id, 3'd0);
        check("s_bits", tx_bits, 8'h05);
        check("s_busy", busy, 1'b1);
        req_valid = 4'b0000;
        tick(3);
        check("s_hold", tx_bits, 8'h05);
        check("s_ack_pulse", req_ack, '0);
        check("s_nodone", req_done, '0);

        // re-request during gap: grant only GAP+1 clocks after tx_ready
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        check("g_done", req_done, 4'b0001);
        check("g_bits", tx_bits, 8'h00);
        req_data[7:0] = 8'h06;
        req_valid = 4'b0001;
        tick(GAP - 1);
        check("g_busy", busy, 1'b1);
        check("g_noack", req_ack, '0);
        tick();
        check("g_idle", busy, 1'b0);
        check("g_noack2", req_ack, '0);
        tick();
        check("g_ack", req_ack, 4'b0001);
        check("g_bits2", tx_bits, 8'h06);
        req_valid = 4'b0000;
        send_done(4'b0001);

        // tx_ready outside SEND is ignored
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        check("o_done", req_done, '0);
        check("o_busy", busy, 1'b0);
        check("o_bits", tx_bits, 8'h00);

        // reset in the middle of SEND abandons the byte
        req_valid = 4'b0100;
        tick();
        check("r_ack", req_ack, 4'b0100);
        req_valid = 4'b0000;
        tick(2);
        reset = 1'b0;
        #1;
        check("r_busy", busy, 1'b0);
        check("r_bits", tx_bits, 8'h00);
        check("r_gid", grant_id, 3'd3);
        tick();
        reset = 1'b1;
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        check("r_nodone", req_done, '0);
        check("r_idle", busy, 1'b0);

        // all requesters held: strict round robin from reset
        req_data  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            wait_ack();
            check("rr_ack", req_ack, 4'b0001 << (k % 4));
            check("rr_gid", grant_id, k % 4);
            check("rr_bits", tx_bits, 8'hA0 + 8'h11 * (k % 4));
            send_done(4'b0001 << (k % 4));
        end
        req_valid = 4'b0000;

        // block holds off new grants but not the byte in flight
        block = 1'b1;
        req_data[23:16] = 8'h8A;
        req_valid = 4'b0100;
        tick(5);
        check("b_noack", req_ack, '0);
        check("b_bits", tx_bits, 8'h00);
        check("b_busy", busy, 1'b0);
        block = 1'b0;
        tick();
        check("b_ack", req_ack, 4'b0100);
        check("b_bits2", tx_bits, 8'h8A);
        check("b_gid", grant_id, 3'd2);
        block = 1'b1;
        req_valid = 4'b1111;
        tick(3);
        check("b_hold", tx_bits, 8'h8A);
        check("b_noack2", req_ack, '0);
        send_done(4'b0100);
        tick(5);
        check("b_blocked", busy, 1'b0);
        check("b_noack3", req_ack, '0);
        block = 1'b0;
        tick();
        check("b_ack2", req_ack, 4'b1000);
        check("b_gid2", grant_id, 3'd3);
        req_valid = 4'b0000;
        send_done(4'b1000);

        // SEND watchdog
        req_valid = 4'b0010;
        tick();
        check("t_ack", req_ack, 4'b0010);
        req_valid = 4'b0000;
`ifdef UART_TX_TIMEOUT_EN
        tick(63);
        check("t_noerr", tx_err, 1'b0);
        check("t_bits", tx_bits, 8'hB1);
        tick();
        check("t_err", tx_err, 1'b1);
        check("t_done", req_done, 4'b0010);
        check("t_cnt", timeout_cnt, 8'd1);
        check("t_gap", tx_bits, 8'h00);
        tick();
        check("t_err_pulse", tx_err, 1'b0);
        tick(GAP - 1);
        check("t_idle", busy, 1'b0);
        req_valid = 4'b0001;
        tick();
        check("t_next", req_ack, 4'b0001);
        req_valid = 4'b0000;
        send_done(4'b0001);
        check("t_cnt2", timeout_cnt, 8'd1);
`else
        tick(100);
        check("t_noerr", tx_err, 1'b0);
        check("t_cnt", timeout_cnt, 8'd0);
        check("t_bits", tx_bits, 8'hB1);
        check("t_busy", busy, 1'b1);
        send_done(4'b0010);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
